// File: rtl/cnn_bn_relu_stream.sv
// Per-channel batch-norm (scale/bias) + ReLU over a channel-major conv output stream.
// Parameters are loaded serially once, then pixels flow through a fixed 3-stage pipeline.
module cnn_bn_relu_stream #(
  parameter int DATA_WIDTH      = 32,
  parameter int FRAC_BITS       = 16,
  parameter int IMAGE_WIDTH     = 153,
  parameter int IMAGE_HEIGHT    = 153,
  parameter int CHANNEL_NUM_OUT = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_param_in,
  input  logic [DATA_WIDTH-1:0] param_in,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  param_ready,
  output logic                  frame_done
);

  localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int PIX_W      = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int CH_W       = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
  localparam int PW         = 2 * DATA_WIDTH;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMAGE_SIZE - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNEL_NUM_OUT - 1);
  localparam logic [CH_W:0]    PRM_LAST = (CH_W + 1)'(2 * CHANNEL_NUM_OUT - 1);

  localparam logic signed [PW-1:0] SAT_MAX = {{(DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};

  typedef enum logic {
    LOAD,
    RUN
  } state_t;

  state_t state, state_nxt;

  logic [CH_W:0]      prm_cnt;
  logic [PIX_W-1:0]   pix_cnt;
  logic [CH_W-1:0]    ch_cnt;
  logic [CH_W-1:0]    prm_ch;
  logic               prm_we;
  logic               accept;
  logic               last_pix;

  logic [DATA_WIDTH-1:0] scale_ram [CHANNEL_NUM_OUT];
  logic [DATA_WIDTH-1:0] bias_ram  [CHANNEL_NUM_OUT];

  // Pipeline registers
  logic                         v1, v2;
  logic                         last1, last2;
  logic signed [DATA_WIDTH-1:0] x1, scale1, bias1, bias2;
  logic signed [PW-1:0]         p2;

  logic signed [PW-1:0]         prod;
  logic signed [PW-1:0]         sum;
  logic [DATA_WIDTH-1:0]        y;

  assign prm_we      = (state == LOAD) && valid_param_in;
  assign accept      = (state == RUN) && valid_in;
  assign prm_ch      = prm_cnt[CH_W:1];
  assign last_pix    = (pix_cnt == PIX_LAST) && (ch_cnt == CH_LAST);
  assign param_ready = (state == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (prm_we && (prm_cnt == PRM_LAST)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prm_cnt <= '0;
      pix_cnt <= '0;
      ch_cnt  <= '0;
    end else begin
      if (prm_we) begin
        prm_cnt <= (prm_cnt == PRM_LAST) ? '0 : prm_cnt + (CH_W + 1)'(1);
      end
      if (accept) begin
        if (pix_cnt == PIX_LAST) begin
          pix_cnt <= '0;
          ch_cnt  <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + CH_W'(1);
        end else begin
          pix_cnt <= pix_cnt + PIX_W'(1);
        end
      end
    end
  end

  // Parameter RAMs: no reset, read every cycle at the current channel so the
  // coefficients land in S1 alongside the accepted pixel.
  always_ff @(posedge clk) begin
    if (prm_we) begin
      if (prm_cnt[0]) bias_ram[prm_ch] <= param_in;
      else            scale_ram[prm_ch] <= param_in;
    end
    scale1 <= scale_ram[ch_cnt];
    bias1  <= bias_ram[ch_cnt];
  end

  always_comb begin
    prod = $signed({{DATA_WIDTH{x1[DATA_WIDTH-1]}}, x1}) *
           $signed({{DATA_WIDTH{scale1[DATA_WIDTH-1]}}, scale1});
    sum  = p2 + $signed({{DATA_WIDTH{bias2[DATA_WIDTH-1]}}, bias2});
    // Negative saturation is subsumed by the ReLU clamp to zero.
    if (sum[PW-1]) begin
      y = '0;
    end else if (sum > SAT_MAX) begin
      y = OUT_MAX;
    end else begin
      y = sum[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      last1      <= 1'b0;
      last2      <= 1'b0;
      x1         <= '0;
      p2         <= '0;
      bias2      <= '0;
      pxl_out    <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // S1
      v1    <= accept;
      last1 <= accept && last_pix;
      if (accept) x1 <= pxl_in;
      // S2
      v2    <= v1;
      last2 <= last1;
      p2    <= prod >>> FRAC_BITS;
      bias2 <= bias1;
      // S3
      valid_out  <= v2;
      frame_done <= v2 && last2;
      if (v2) pxl_out <= y;
    end
  end

endmodule
